// File: rtl/data_bus_master.sv
// data_bus_master: initiator side of the shared data bus.
//
// Turns load/store requests from the execute stage into bus transactions for the
// program-flash and RAM responders.
//
// Transaction flow:
// - Loads take two bus cycles, LD_ADDR then LD_DATA.
// - stall_lw is raised during LD_ADDR only.
// - Stores take one bus cycle, ST, which is the only cycle that drives data_bus_data.
//
// Optional feature, enabled by defining DATA_BUS_MISALIGN_TRAP_EN:
// - Misaligned word and half-word requests are rejected while idle.
// - A rejected request raises a one-cycle fault pulse.
//
// Ports:
//   clk, reset            core clock; asynchronous active-low reset
//   req_valid/_write/_addr/_width/_signed/_wdata
//                         request from the execute stage; sampled only while busy=0
//   busy                  transaction in progress; the pipeline must hold
//   rdata, rdata_valid    last load result and its one-cycle update pulse
//   fault                 one-cycle pulse on a rejected misaligned request
//   data_bus_data         shared tri-state data lines
//   data_bus_addr/_mode/_reqw/_reqs
//                         bus address, mode (00 idle, 01 read, 10 write),
//                         access width and signed-load flag
//   stall_lw              first stall cycle of a load
module data_bus_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_width,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              fault,
  inout  wire  [DATA_W-1:0] data_bus_data,
  output logic [ADDR_W-1:0] data_bus_addr,
  output logic [1:0]        data_bus_mode,
  output logic [1:0]        data_bus_reqw,
  output logic              data_bus_reqs,
  output logic              stall_lw
);

  typedef enum logic [1:0] {StIdle, StLdAddr, StLdData, StSt} state_e;

  localparam logic [1:0] ModeIdle  = 2'b00;
  localparam logic [1:0] ModeRead  = 2'b01;
  localparam logic [1:0] ModeWrite = 2'b10;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        width_q, width_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              fault_q, fault_d;

  logic              misaligned;
  logic              accept;
  logic              drive_en;
  logic [DATA_W-1:0] wdata_bus;

`ifdef DATA_BUS_MISALIGN_TRAP_EN
  // Width 11 is checked with the word rule, which also covers the half-word rule.
  assign misaligned = ((req_width == 2'b00 || req_width == 2'b11) && req_addr[1:0] != 2'b00) ||
                      (req_width == 2'b01 && req_addr[0]);
`else
  assign misaligned = 1'b0;
`endif

  assign accept = (state_q == StIdle) && req_valid && !misaligned;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      width_q       <= 2'b00;
      sign_q        <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      width_q       <= width_d;
      sign_q        <= sign_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = req_write ? StSt : StLdAddr;
        end
      end
      StLdAddr: state_d = StLdData;
      StLdData: state_d = StIdle;
      StSt:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Request capture, load-result capture and status pulses.
  always_comb begin
    addr_d        = addr_q;
    width_d       = width_q;
    sign_d        = sign_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    fault_d       = 1'b0;
    if (accept) begin
      addr_d  = req_addr;
      width_d = req_width;
      sign_d  = req_signed;
      wdata_d = req_wdata;
    end
    if (state_q == StLdData) begin
      // The responder has already extended the value to the full bus width.
      rdata_d       = data_bus_data;
      rdata_valid_d = 1'b1;
    end
    if (state_q == StIdle && req_valid && misaligned) begin
      fault_d = 1'b1;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    data_bus_mode = ModeIdle;
    stall_lw      = 1'b0;
    busy          = 1'b1;
    drive_en      = 1'b0;
    case (state_q)
      StIdle:   busy = 1'b0;
      StLdAddr: begin
        data_bus_mode = ModeRead;
        stall_lw      = 1'b1;
      end
      StLdData: data_bus_mode = ModeRead;
      StSt: begin
        data_bus_mode = ModeWrite;
        drive_en      = 1'b1;
      end
      default:  busy = 1'b0;
    endcase
  end

  // Store data sits in the low lanes, zero-extended; width 11 drives the full word.
  always_comb begin
    case (width_q)
      2'b01:   wdata_bus = {{(DATA_W-16){1'b0}}, wdata_q[15:0]};
      2'b10:   wdata_bus = {{(DATA_W-8){1'b0}}, wdata_q[7:0]};
      default: wdata_bus = wdata_q;
    endcase
  end

  assign data_bus_data = drive_en ? wdata_bus : {DATA_W{1'bz}};

  assign data_bus_addr = addr_q;
  assign data_bus_reqw = width_q;
  assign data_bus_reqs = sign_q;
  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_data_bus_master.sv
// Self-checking bench for data_bus_master.
// The reference model tracks each accepted transaction by the cycle on which it was
// accepted. Every expected output is derived from the age of that transaction.
// The bench drives the data lines itself on every cycle where the master must not drive,
// so a master that fails to release the bus corrupts the value read back.
module tb_data_bus_master;

`ifdef DATA_BUS_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_width;
  logic        busy, rdata_valid, fault, stall_lw, data_bus_reqs;
  logic [31:0] rdata, data_bus_addr;
  logic [1:0]  data_bus_mode, data_bus_reqw;
  tri   [31:0] data_bus_data;
  logic        tb_drv_en;
  logic [31:0] tb_drv_val;

  assign data_bus_data = tb_drv_en ? tb_drv_val : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  data_bus_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_width    (req_width),
    .req_signed   (req_signed),
    .req_wdata    (req_wdata),
    .busy         (busy),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .fault        (fault),
    .data_bus_data(data_bus_data),
    .data_bus_addr(data_bus_addr),
    .data_bus_mode(data_bus_mode),
    .data_bus_reqw(data_bus_reqw),
    .data_bus_reqs(data_bus_reqs),
    .stall_lw     (stall_lw)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int          cyc;
  int          acc_cyc;
  bit          acc_ld;
  logic [31:0] m_addr, m_wdata, m_rdata, m_resp;
  logic [1:0]  m_width;
  bit          m_sign;
  bit          m_fault_now;
  logic [31:0] last_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wexp(input logic [1:0] w, input logic [31:0] d);
    case (w)
      2'b01:   return {16'h0, d[15:0]};
      2'b10:   return {24'h0, d[7:0]};
      default: return d;
    endcase
  endfunction

  function automatic bit misal(input logic [31:0] a, input logic [1:0] w);
    return ((w == 2'b00 || w == 2'b11) && a[1:0] != 2'b00) || (w == 2'b01 && a[0]);
  endfunction

  task automatic model_reset();
    acc_cyc     = -1000;
    acc_ld      = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    m_rdata     = '0;
    m_resp      = '0;
    m_width     = 2'b00;
    m_sign      = 1'b0;
    m_fault_now = 1'b0;
  endtask

  // One clock cycle: entered just after a rising edge, returns just after the next one.
  task automatic cycle(input bit v, input bit w, input logic [31:0] a, input logic [1:0] wd,
                       input bit s, input logic [31:0] wdat, input logic [31:0] resp);
    int d;
    bit ld_addr, ld_data, st, idle;
    d       = cyc - acc_cyc;
    ld_addr = acc_ld && d == 1;
    ld_data = acc_ld && d == 2;
    st      = !acc_ld && d == 1;
    idle    = !(ld_addr || ld_data || st);
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_width  = wd;
    req_signed = s;
    req_wdata  = wdat;
    tb_drv_en  = !st;
    tb_drv_val = ld_data ? m_resp : $urandom;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(!idle));
    chk("mode", 32'(data_bus_mode), (ld_addr || ld_data) ? 32'd1 : (st ? 32'd2 : 32'd0));
    chk("stall_lw", 32'(stall_lw), 32'(ld_addr));
    chk("rdata_valid", 32'(rdata_valid), 32'(acc_ld && d == 3));
    chk("rdata", rdata, m_rdata);
    chk("fault", 32'(fault), 32'(m_fault_now));
    if (!idle) begin
      chk("addr", data_bus_addr, m_addr);
      chk("reqw", 32'(data_bus_reqw), 32'(m_width));
      chk("reqs", 32'(data_bus_reqs), 32'(m_sign));
    end
    if (st) begin
      last_st = data_bus_data;
      chk("st_data", data_bus_data, wexp(m_width, m_wdata));
    end else begin
      chk("bus_released", data_bus_data, tb_drv_val);
    end
    @(posedge clk);
    if (ld_data) m_rdata = m_resp;
    m_fault_now = 1'b0;
    if (idle && v) begin
      if (Trap && misal(a, wd)) begin
        m_fault_now = 1'b1;
      end else begin
        acc_cyc = cyc;
        acc_ld  = !w;
        m_addr  = a;
        m_width = wd;
        m_sign  = s;
        m_wdata = wdat;
        m_resp  = resp;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  width;
    bit          sgn;
    logic [31:0] wdata;
    logic [31:0] resp;
    logic [31:0] exp;   // load: expected rdata; store: expected bus word
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0100, 2'b00, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_3004, 2'b10, 1'b0, 32'h1234_56A5, 32'h0, 32'h0000_00A5};
    vecs[2] = '{1'b0, 32'h0000_0202, 2'b01, 1'b1, 32'h0, 32'hFFFF_8001, 32'hFFFF_8001};
    vecs[3] = '{1'b1, 32'h0000_2002, 2'b01, 1'b0, 32'hCAFE_BEEF, 32'h0, 32'h0000_BEEF};
    vecs[4] = '{1'b1, 32'h0000_0040, 2'b00, 1'b0, 32'h89AB_CDEF, 32'h0, 32'h89AB_CDEF};
    vecs[5] = '{1'b0, 32'h0000_0007, 2'b10, 1'b0, 32'h0, 32'h0000_00C3, 32'h0000_00C3};

    // Power-on reset.
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_width  = 2'b00;
    req_signed = 1'b0;
    req_wdata  = '0;
    tb_drv_en  = 1'b1;
    tb_drv_val = 32'h0F0F_0F0F;
    cyc        = 0;
    last_st    = '0;
    model_reset();
    #12;
    chk("por_busy", 32'(busy), 32'd0);
    chk("por_mode", 32'(data_bus_mode), 32'd0);
    chk("por_addr", data_bus_addr, 32'd0);
    chk("por_reqw", 32'(data_bus_reqw), 32'd0);
    chk("por_reqs", 32'(data_bus_reqs), 32'd0);
    chk("por_stall", 32'(stall_lw), 32'd0);
    chk("por_rdata", rdata, 32'd0);
    chk("por_rvalid", 32'(rdata_valid), 32'd0);
    chk("por_fault", 32'(fault), 32'd0);
    chk("por_bus", data_bus_data, 32'h0F0F_0F0F);
    @(posedge clk);
    #1 reset = 1'b1;
    idle_cycles(2);

    // Directed table: loads end with rdata checked, stores with the bus word checked.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].width, vecs[i].sgn, vecs[i].wdata,
            vecs[i].resp);
      if (vecs[i].wr) begin
        idle_cycles(1);
        chk($sformatf("vec%0d_store_word", i), last_st, vecs[i].exp);
        idle_cycles(1);
      end else begin
        idle_cycles(3);
        chk($sformatf("vec%0d_load_rdata", i), rdata, vecs[i].exp);
      end
    end

    // Load to 0x10 followed by a store issued in the rdata_valid cycle.
    cycle(1'b1, 1'b0, 32'h0000_0010, 2'b00, 1'b0, 32'h0, 32'h0BAD_CAFE);
    idle_cycles(2);
    cycle(1'b1, 1'b1, 32'h0000_0014, 2'b00, 1'b0, 32'h7654_3210, 32'h0);
    idle_cycles(1);
    chk("b2b_store_word", last_st, 32'h7654_3210);
    chk("b2b_rdata_kept", rdata, 32'h0BAD_CAFE);
    idle_cycles(2);

    // Misaligned word load: trapped when the feature is built in, otherwise a normal load.
    cycle(1'b1, 1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0, 32'h0000_0000);
    idle_cycles(4);

    // Reset asserted during LD_ADDR.
    cycle(1'b1, 1'b0, 32'h0000_0200, 2'b00, 1'b0, 32'h0, 32'h5555_AAAA);
    req_valid  = 1'b0;
    tb_drv_en  = 1'b1;
    tb_drv_val = 32'h1357_9BDF;
    chk("pre_rst_stall", 32'(stall_lw), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mode", 32'(data_bus_mode), 32'd0);
    chk("rst_stall", 32'(stall_lw), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rvalid", 32'(rdata_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_bus", data_bus_data, 32'h1357_9BDF);
    chk("rst_addr", data_bus_addr, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    idle_cycles(3);

    // Randomized traffic against the model, including requests held while busy.
    for (int i = 0; i < 600; i++) begin
      bit          v, w, s;
      logic [1:0]  wd;
      logic [31:0] a;
      v  = ($urandom_range(0, 2) != 0);
      w  = $urandom_range(0, 1) == 1;
      s  = $urandom_range(0, 1) == 1;
      wd = w ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
      a  = $urandom;
      cycle(v, w, a, wd, s, $urandom, $urandom);
    end
    idle_cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_bus_master.md
Name: data_bus_master

Overview:
- Initiator side of the shared data bus. Turns load/store requests from the execute stage into bus transactions for the program-flash and RAM responders.
- Drives the address, mode, width and sign lines and generates `stall_lw` for the one-cycle flash load stall.
- Drives write data onto the tri-state bus and captures load results.
- Sits between the execute stage and all data-bus responders; exactly one instance per core.

Parameters:
- ADDR_W, 32, width of `req_addr` and `data_bus_addr`.
- DATA_W, 32, width of the data bus; only 32 is supported.

Ports:
- clk  input  1  core clock; all state on the rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present; sampled only while busy=0
- req_write  input  1  1=store, 0=load
- req_addr  input  32  byte address
- req_width  input  2  00 word, 01 half-word, 10 byte, 11 reserved
- req_signed  input  1  load sign extension, 1=signed
- req_wdata  input  32  store data, value in the low bits
- busy  output  1  transaction in progress; the pipeline must hold
- rdata  output  32  last load result, already extended by the responder
- rdata_valid  output  1  one-cycle pulse when rdata is updated
- fault  output  1  one-cycle pulse on a rejected misaligned request (feature only)
- data_bus_data  inout  32  shared data lines
- data_bus_addr  output  32  bus address
- data_bus_mode  output  2  00 idle, 01 read, 10 write, 11 unused
- data_bus_reqw  output  2  access width, same encoding as req_width
- data_bus_reqs  output  1  signed-load flag
- stall_lw  output  1  first stall cycle of a load

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is asynchronous and active-low.
- Reset values: state IDLE; data_bus_addr=0; data_bus_mode=00; data_bus_reqw=00; data_bus_reqs=0; stall_lw=0; rdata=0; rdata_valid=0; fault=0; busy=0; data_bus_data=Z.
- Request registers (addr, width, sign, wdata) load on the accepting edge and are held stable until the FSM returns to IDLE.
- States: IDLE, LD_ADDR, LD_DATA, ST.
- IDLE:
  - mode=00 and the bus is released.
  - On an edge with req_valid=1, go to LD_ADDR (load) or ST (store).
- LD_ADDR:
  - mode=01, stall_lw=1, registered address on the bus.
  - The responder's memory register fills on the next edge.
  - Always goes to LD_DATA.
- LD_DATA:
  - mode=01, stall_lw=0, address, width and sign held so the responder's lane select stays correct.
  - The edge captures data_bus_data into rdata and goes to IDLE.
  - rdata_valid=1 during the following IDLE cycle.
- ST:
  - mode=10 and data_bus_data driven for exactly this cycle:
    - word: wdata;
    - half-word: {16'h0, wdata[15:0]};
    - byte: {24'h0, wdata[7:0]}.
  - The write commits at the edge ending ST; go to IDLE.
  - No rdata_valid is generated.
- busy=1 in every state except IDLE.
- Latency, request edge to rdata_valid high: load 3 cycles, store 2-cycle occupancy.
- data_bus_data is driven only in ST; Z in all other states, including during reset.
- Back-to-back: a request accepted in the IDLE cycle where rdata_valid=1 is legal; rdata keeps the old result until the new LD_DATA edge.
- Width 11 is passed to the bus unchanged; the responder decides the result.
- Address range is not checked; the responder decodes the address.
- Reset mid-transaction: immediate return to IDLE, bus released, no rdata_valid or fault pulse, rdata cleared.

Optional Feature:
- Macro: DATA_BUS_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned requests are rejected in IDLE: word with addr[1:0]!=0, or half-word with addr[0]=1 (both are also flagged when width=11).
  - The FSM stays in IDLE, mode stays 00, and fault=1 for the next cycle.
  - rdata is unchanged and no rdata_valid pulse occurs.
- Undefined:
  - fault is tied to 0 and all requests go to the bus.
  - Example: a half-word load at byte offset 3 returns whatever the responder gives (0 for flash).

Test Plan:
1. Reset low mid-LD_ADDR -> next cycle mode=00, stall_lw=0, data_bus_data=Z, rdata=0, no rdata_valid pulse.
2. Word load, addr 0x0000_0100, bus returns 0xDEADBEEF -> stall_lw high exactly 1 cycle; mode=01 for 2 cycles; rdata=0xDEADBEEF with rdata_valid 3 cycles after request.
3. Byte store, addr 0x3004, wdata 0x1234_56A5 -> one cycle with mode=10, reqw=10, addr=0x3004, data_bus_data=0x0000_00A5; Z before and after.
4. Load to 0x10 immediately followed by a store issued in the rdata_valid cycle -> rdata valid, then ST starts on the next edge; no bus cycle with both mode=01 and a driven data bus.
5. Signed half-word load, addr 0x202: reqs=1, reqw=01 held through LD_DATA -> rdata equals bus value 0xFFFF_8001.
6. With DATA_BUS_MISALIGN_TRAP_EN, word load at 0x103 -> fault pulse 1 cycle, mode stays 00, busy=0. Without it -> a normal 3-cycle load.
